cp0_exc_ctrl: RTL and testbench

Coprocessor-0 exception/interrupt controller at the M stage.
- Consumes the exception metadata (PC, BD, ExcCode) carried down the pipeline registers.
- Decides whether to take an exception or interrupt, and drives Req back to every pipeline register to flush and redirect to 0x0000_4180.
- Holds the SR, Cause, EPC and PRId registers and serves mtc0, mfc0 and eret.

---
 rtl/cp0_exc_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_cp0_exc_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exc_ctrl.sv
// -----------------------------------------------------------------------------
// cp0_exc_ctrl
//
// Coprocessor-0 exception/interrupt controller sitting at the M stage. It looks
// at the exception metadata carried down the pipeline (PC, BD, ExcCode) and
// the external interrupt lines. It raises Req in the same cycle when an
// exception or interrupt must be taken, which flushes the pipeline registers
// and redirects fetch to Handler_out. It also owns the SR, Cause, EPC and
// PRId registers and services mtc0 / mfc0 / eret.
//
// Optional feature macro: CP0_BADVADDR_EN
//   When defined, adds a read-only BadVAddr register (reg 8). It is loaded
//   from BadVAddr_in when an AdEL/AdES exception (code 4/5) is taken.
//   When undefined, reg 8 reads 0 and BadVAddr_in is ignored.
//
// Ports:
//   Clk          rising-edge clock
//   Rst          asynchronous active-high reset
//   PC_in        PC of the instruction in M
//   BD_in        instruction in M sits in a branch delay slot
//   ExcCode_in   exception code from M (5'd31 = none)
//   HWInt        level-sensitive external interrupt lines
//   BadVAddr_in  faulting address (optional feature only)
//   A1           mfc0 register number
//   A2           mtc0 register number
//   Din          mtc0 write data
//   We           mtc0 write enable
//   EXLClr       eret in M
//   Dout         mfc0 read data (combinational from A1)
//   EPC_out      EPC with mtc0 bypass (combinational)
//   Handler_out  exception entry address (constant)
//   Req          take exception/interrupt this cycle (combinational)
// -----------------------------------------------------------------------------
module cp0_exc_ctrl #(
    parameter logic [31:0] PRID       = 32'h2021_0B0A,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] PC_in,
    input  logic        BD_in,
    input  logic [4:0]  ExcCode_in,
    input  logic [5:0]  HWInt,
    input  logic [31:0] BadVAddr_in,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] Din,
    input  logic        We,
    input  logic        EXLClr,
    output logic [31:0] Dout,
    output logic [31:0] EPC_out,
    output logic [31:0] Handler_out,
    output logic        Req
);

    // The EXL bit is the controller state: HANDLER means EXL=1.
    typedef enum logic {
        NORMAL  = 1'b0,
        HANDLER = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic        exl;
    logic [5:0]  sr_im;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;
    logic        int_req;
    logic        exc_req;
    logic        wr_sr;
    logic        wr_epc;
    logic [31:0] pc_aligned;
    logic [31:0] epc_take;
    logic        unused_inputs;

    assign exl = (state == HANDLER);

    assign int_req = (|(HWInt & sr_im)) & sr_ie & ~exl;
    assign exc_req = (ExcCode_in != 5'd31) & ~exl;
    assign Req     = int_req | exc_req;

    // A taken exception discards any mtc0 in the same cycle.
    assign wr_sr  = We & (A2 == 5'd12) & ~Req;
    assign wr_epc = We & (A2 == 5'd14) & ~Req;

    // Delay-slot instructions restart at the branch, one word earlier.
    // Subtraction wraps, so PC 0 in a delay slot yields 32'hFFFF_FFFC.
    assign pc_aligned = {PC_in[31:2], 2'b00};
    assign epc_take   = BD_in ? (pc_aligned - 32'd4) : pc_aligned;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= NORMAL;
        end else begin
            state <= state_nxt;
        end
    end

    // An eret together with an SR write lets the written IM/IE land but
    // always leaves EXL cleared.
    always_comb begin
        state_nxt = state;
        if (Req) begin
            state_nxt = HANDLER;
        end else begin
            if (wr_sr) begin
                state_nxt = Din[1] ? HANDLER : NORMAL;
            end
            if (EXLClr) begin
                state_nxt = NORMAL;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sr_im     <= 6'd0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= 6'd0;
            cause_exc <= 5'd0;
            epc       <= 32'd0;
        end else begin
            // IP mirrors the raw interrupt lines every cycle.
            cause_ip <= HWInt;
            if (Req) begin
                cause_bd  <= BD_in;
                cause_exc <= int_req ? 5'd0 : ExcCode_in;
                epc       <= epc_take;
            end else begin
                if (wr_sr) begin
                    sr_im <= Din[15:10];
                    sr_ie <= Din[0];
                end
                if (wr_epc) begin
                    epc <= Din;
                end
            end
        end
    end

`ifdef CP0_BADVADDR_EN
    logic [31:0] badvaddr;

    // Only address-error exceptions capture the address; an interrupt that
    // wins priority over a pending exception leaves it untouched.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            badvaddr <= 32'd0;
        end else if (exc_req && !int_req &&
                     (ExcCode_in == 5'd4 || ExcCode_in == 5'd5)) begin
            badvaddr <= BadVAddr_in;
        end
    end

    assign unused_inputs = ^PC_in[1:0];
`else
    assign unused_inputs = ^{PC_in[1:0], BadVAddr_in};
`endif

    always_comb begin
        Dout = 32'd0;
        case (A1)
`ifdef CP0_BADVADDR_EN
            5'd8:    Dout = badvaddr;
`endif
            5'd12:   Dout = {16'd0, sr_im, 8'd0, exl, sr_ie};
            5'd13:   Dout = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc, 2'd0};
            5'd14:   Dout = epc;
            5'd15:   Dout = PRID;
            default: Dout = 32'd0;
        endcase
    end

    // Bypass so an eret right after an mtc0 to EPC returns to the new value.
    assign EPC_out     = (We && A2 == 5'd14) ? Din : epc;
    assign Handler_out = HANDLER_PC;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
module tb_cp0_exc_ctrl;

    localparam logic [31:0] PRID       = 32'h2021_0B0A;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

    logic        Clk;
    logic        Rst;
    logic [31:0] PC_in;
    logic        BD_in;
    logic [4:0]  ExcCode_in;
    logic [5:0]  HWInt;
    logic [31:0] BadVAddr_in;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] Din;
    logic        We;
    logic        EXLClr;
    logic [31:0] Dout;
    logic [31:0] EPC_out;
    logic [31:0] Handler_out;
    logic        Req;

    int pass_cnt  = 0;
    int total_cnt = 0;

    cp0_exc_ctrl #(
        .PRID       (PRID),
        .HANDLER_PC (HANDLER_PC)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .PC_in       (PC_in),
        .BD_in       (BD_in),
        .ExcCode_in  (ExcCode_in),
        .HWInt       (HWInt),
        .BadVAddr_in (BadVAddr_in),
        .A1          (A1),
        .A2          (A2),
        .Din         (Din),
        .We          (We),
        .EXLClr      (EXLClr),
        .Dout        (Dout),
        .EPC_out     (EPC_out),
        .Handler_out (Handler_out),
        .Req         (Req)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        A1 = a;
        #1;
        d = Dout;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rd(5'd15, d);
        total_cnt++;
        if (d !== PRID) $display("FAIL reset_prid got=%h exp=%h", d, PRID); else pass_cnt++;
        rd(5'd12, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL reset_sr got=%h exp=%h", d, 32'h0); else pass_cnt++;
        rd(5'd13, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL reset_cause got=%h exp=%h", d, 32'h0); else pass_cnt++;
        rd(5'd14, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL reset_epc got=%h exp=%h", d, 32'h0); else pass_cnt++;
        total_cnt++;
        if (Req !== 1'b0) $display("FAIL reset_req got=%b exp=0", Req); else pass_cnt++;
        total_cnt++;
        if (EPC_out !== 32'h0) $display("FAIL reset_epc_out got=%h exp=0", EPC_out); else pass_cnt++;
        total_cnt++;
        if (Handler_out !== HANDLER_PC) $display("FAIL handler_pc got=%h exp=%h", Handler_out, HANDLER_PC); else pass_cnt++;
    endtask

    task automatic test_interrupt();
        logic [31:0] d;
        We = 1'b1; A2 = 5'd12; Din = 32'h0000_FC01; HWInt = 6'd0;
        tick();
        We = 1'b0;
        rd(5'd12, d);
        total_cnt++;
        if (d !== 32'h0000_FC01) $display("FAIL int_sr_write got=%h exp=%h", d, 32'h0000_FC01); else pass_cnt++;
        HWInt = 6'b000100; PC_in = 32'h0000_2000; BD_in = 1'b0;
        #1;
        total_cnt++;
        if (Req !== 1'b1) $display("FAIL int_req got=%b exp=1", Req); else pass_cnt++;
        tick();
        rd(5'd13, d);
        total_cnt++;
        if (d !== 32'h0000_1000) $display("FAIL int_cause got=%h exp=%h", d, 32'h0000_1000); else pass_cnt++;
        rd(5'd12, d);
        total_cnt++;
        if (d !== 32'h0000_FC03) $display("FAIL int_sr_exl got=%h exp=%h", d, 32'h0000_FC03); else pass_cnt++;
        rd(5'd14, d);
        total_cnt++;
        if (d !== 32'h0000_2000) $display("FAIL int_epc got=%h exp=%h", d, 32'h0000_2000); else pass_cnt++;
        total_cnt++;
        if (Req !== 1'b0) $display("FAIL int_req_masked_exl got=%b exp=0", Req); else pass_cnt++;
    endtask

    task automatic test_exception();
        logic [31:0] d;
        HWInt = 6'd0; EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
        ExcCode_in = 5'd10; BD_in = 1'b1; PC_in = 32'h0000_3008;
        #1;
        total_cnt++;
        if (Req !== 1'b1) $display("FAIL exc_req got=%b exp=1", Req); else pass_cnt++;
        tick();
        ExcCode_in = 5'd31; BD_in = 1'b0;
        rd(5'd14, d);
        total_cnt++;
        if (d !== 32'h0000_3004) $display("FAIL exc_epc_bd got=%h exp=%h", d, 32'h0000_3004); else pass_cnt++;
        rd(5'd13, d);
        total_cnt++;
        if (d !== 32'h8000_0028) $display("FAIL exc_cause got=%h exp=%h", d, 32'h8000_0028); else pass_cnt++;
        total_cnt++;
        if (Req !== 1'b0) $display("FAIL exc_req_after got=%b exp=0", Req); else pass_cnt++;
    endtask

    task automatic test_eret_race();
        logic [31:0] d;
        EXLClr = 1'b1; ExcCode_in = 5'd12; PC_in = 32'h0000_4000; BD_in = 1'b0;
        #1;
        total_cnt++;
        if (Req !== 1'b0) $display("FAIL eret_same_cycle_req got=%b exp=0", Req); else pass_cnt++;
        tick();
        EXLClr = 1'b0;
        #1;
        total_cnt++;
        if (Req !== 1'b1) $display("FAIL eret_next_cycle_req got=%b exp=1", Req); else pass_cnt++;
        tick();
        ExcCode_in = 5'd31;
        rd(5'd13, d);
        total_cnt++;
        if (d !== 32'h0000_0030) $display("FAIL eret_cause got=%h exp=%h", d, 32'h0000_0030); else pass_cnt++;
        rd(5'd14, d);
        total_cnt++;
        if (d !== 32'h0000_4000) $display("FAIL eret_epc got=%h exp=%h", d, 32'h0000_4000); else pass_cnt++;
    endtask

    task automatic test_mtc0_epc();
        logic [31:0] d;
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
        We = 1'b1; A2 = 5'd14; Din = 32'h0000_3100;
        ExcCode_in = 5'd10; BD_in = 1'b1; PC_in = 32'h0000_3008;
        #1;
        total_cnt++;
        if (Req !== 1'b1) $display("FAIL mtc0_race_req got=%b exp=1", Req); else pass_cnt++;
        tick();
        We = 1'b0; ExcCode_in = 5'd31; BD_in = 1'b0;
        rd(5'd14, d);
        total_cnt++;
        if (d !== 32'h0000_3004) $display("FAIL mtc0_discarded_epc got=%h exp=%h", d, 32'h0000_3004); else pass_cnt++;
        We = 1'b1; A2 = 5'd14; Din = 32'h0000_3100;
        #1;
        total_cnt++;
        if (EPC_out !== 32'h0000_3100) $display("FAIL epc_bypass got=%h exp=%h", EPC_out, 32'h0000_3100); else pass_cnt++;
        tick();
        We = 1'b0;
        rd(5'd14, d);
        total_cnt++;
        if (d !== 32'h0000_3100) $display("FAIL mtc0_epc_write got=%h exp=%h", d, 32'h0000_3100); else pass_cnt++;
        total_cnt++;
        if (EPC_out !== 32'h0000_3100) $display("FAIL epc_out_reg got=%h exp=%h", EPC_out, 32'h0000_3100); else pass_cnt++;
    endtask

    task automatic test_pc_wrap();
        logic [31:0] d;
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
        ExcCode_in = 5'd10; BD_in = 1'b1; PC_in = 32'h0000_0000;
        tick();
        ExcCode_in = 5'd31; BD_in = 1'b0;
        rd(5'd14, d);
        total_cnt++;
        if (d !== 32'hFFFF_FFFC) $display("FAIL pc_wrap_epc got=%h exp=%h", d, 32'hFFFF_FFFC); else pass_cnt++;
        // Exception while EXL=1 is ignored.
        ExcCode_in = 5'd4; PC_in = 32'h0000_7000;
        #1;
        total_cnt++;
        if (Req !== 1'b0) $display("FAIL exl_blocks_exc got=%b exp=0", Req); else pass_cnt++;
        tick();
        ExcCode_in = 5'd31;
        rd(5'd14, d);
        total_cnt++;
        if (d !== 32'hFFFF_FFFC) $display("FAIL exl_epc_hold got=%h exp=%h", d, 32'hFFFF_FFFC); else pass_cnt++;
    endtask

    task automatic test_badvaddr();
        logic [31:0] d;
        BadVAddr_in = 32'hDEAD_0001;
`ifdef CP0_BADVADDR_EN
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
        ExcCode_in = 5'd4; PC_in = 32'h0000_6000;
        tick();
        ExcCode_in = 5'd31;
        rd(5'd8, d);
        total_cnt++;
        if (d !== 32'hDEAD_0001) $display("FAIL badvaddr_load got=%h exp=%h", d, 32'hDEAD_0001); else pass_cnt++;
`else
        rd(5'd8, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL badvaddr_absent got=%h exp=0", d); else pass_cnt++;
`endif
        BadVAddr_in = 32'h0;
    endtask

    task automatic test_sr_eret();
        logic [31:0] d;
        We = 1'b1; A2 = 5'd12; Din = 32'h0000_FC03; EXLClr = 1'b1;
        tick();
        We = 1'b0; EXLClr = 1'b0;
        rd(5'd12, d);
        total_cnt++;
        if (d !== 32'h0000_FC01) $display("FAIL sr_write_with_eret got=%h exp=%h", d, 32'h0000_FC01); else pass_cnt++;
    endtask

    task automatic test_priority();
        logic [31:0] d;
        HWInt = 6'b000001; ExcCode_in = 5'd10; BD_in = 1'b0; PC_in = 32'h0000_5000;
        #1;
        total_cnt++;
        if (Req !== 1'b1) $display("FAIL prio_req got=%b exp=1", Req); else pass_cnt++;
        tick();
        HWInt = 6'd0; ExcCode_in = 5'd31;
        rd(5'd13, d);
        total_cnt++;
        if (d !== 32'h0000_0400) $display("FAIL prio_cause got=%h exp=%h", d, 32'h0000_0400); else pass_cnt++;
        rd(5'd14, d);
        total_cnt++;
        if (d !== 32'h0000_5000) $display("FAIL prio_epc got=%h exp=%h", d, 32'h0000_5000); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
        ExcCode_in = 5'd10; BD_in = 1'b1; PC_in = 32'h0000_3008;
        tick();
        ExcCode_in = 5'd31; BD_in = 1'b0;
        rd(5'd14, d);
        total_cnt++;
        if (d !== 32'h0000_3004) $display("FAIL pre_reset_epc got=%h exp=%h", d, 32'h0000_3004); else pass_cnt++;
        // Assert reset between clock edges and check before the next edge.
        Rst = 1'b1;
        rd(5'd12, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL async_rst_sr got=%h exp=0", d); else pass_cnt++;
        rd(5'd13, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL async_rst_cause got=%h exp=0", d); else pass_cnt++;
        rd(5'd14, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL async_rst_epc got=%h exp=0", d); else pass_cnt++;
        total_cnt++;
        if (EPC_out !== 32'h0) $display("FAIL async_rst_epc_out got=%h exp=0", EPC_out); else pass_cnt++;
        total_cnt++;
        if (Req !== 1'b0) $display("FAIL async_rst_req got=%b exp=0", Req); else pass_cnt++;
        tick();
        Rst = 1'b0;
    endtask

    initial begin
        Rst = 1'b1;
        PC_in = 32'h0; BD_in = 1'b0; ExcCode_in = 5'd31; HWInt = 6'd0;
        BadVAddr_in = 32'h0; A1 = 5'd0; A2 = 5'd0; Din = 32'h0;
        We = 1'b0; EXLClr = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b0;
        test_reset();
        test_interrupt();
        test_exception();
        test_eret_race();
        test_mtc0_epc();
        test_pc_wrap();
        test_badvaddr();
        test_sr_eret();
        test_priority();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
